uart_tx_framed: RTL

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx_framed.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_tx_framed_pkg.sv
// Shared encodings for the framed UART transmitter:
// parity modes, FSM states and datapath widths.
package uart_tx_framed_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  function automatic logic par_of(
    input logic red,
    input int   mode
  );
    return (mode == int'(PAR_ODD)) ? ~red : red;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the transmitter.
// Occupancy count is one bit wider than the pointers.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: FIFO-buffered, configurable
// data width, parity and stop bits, back-to-back frames.
module uart_tx_framed
  import uart_tx_framed_pkg::*;
#(
  parameter int CLKS_PER_BIT = 26,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 DATA_READY,
  output logic                 FULL,
  output logic                 TXD,
  output logic                 IDLE,
  output logic                 OVERFLOW
);

  localparam logic PAR_EN = PARITY != int'(PAR_NONE);

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 ovf_q, ovf_d;

  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 pop;
  logic                 bit_end, last_data, last_stop;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .wr_en  (DATA_READY),
    .wr_data(DATA),
    .rd_en  (pop),
    .rd_data(fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_end   = cnt_q == BAUD_W'(CLKS_PER_BIT - 1);
  assign last_data = bit_q == BIT_W'(DATA_BITS - 1);
  assign last_stop = bit_q == BIT_W'(STOP_BITS - 1);

  // Pop from idle, or on the final stop edge for gapless frames.
  assign pop = ~fifo_empty &
               ((state_q == ST_IDLE) |
                ((state_q == ST_STOP) & bit_end & last_stop));

  assign FULL     = fifo_full;
  assign TXD      = txd_q;
  assign OVERFLOW = ovf_q;
  assign IDLE     = fifo_empty & (state_q == ST_IDLE) & ~DATA_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && last_data)
          state_d = PAR_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end && last_stop)
          state_d = pop ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    par_d = par_q;
    ovf_d = ovf_q | (DATA_READY & fifo_full);

    if (state_q == ST_IDLE || bit_end) cnt_d = '0;
    else cnt_d = cnt_q + BAUD_W'(1);

    if (bit_end)
      bit_d = (state_d == state_q) ? bit_q + BIT_W'(1) : '0;

    if (pop) begin
      sh_d  = fifo_rdata;
      par_d = par_of(^fifo_rdata, PARITY);
    end else if (state_q == ST_DATA && bit_end) begin
      sh_d = sh_q >> 1;
    end

    // Driven from next state so TXD leaves a flop cleanly.
    txd_d = 1'b1;
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = sh_d[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = 1'b1;
    endcase
  end

endmodule
